hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_ctrl_if.sv | 29 ++
 rtl/hazard_ctrl_fwd_sel.sv | 21 ++
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects and FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; master is the datapath, slave the hazard unit.
interface hazard_ctrl_if;

  logic [4:0] Rs1D, Rs2D;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic       ResultSrcE0;
  logic       PCSrcE;
  logic [4:0] RdM, RdW;
  logic       RegWriteM, RegWriteW;
  logic       MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE0, PCSrcE,
           RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE0, PCSrcE,
           RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE
  );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forwarding select: the Memory stage wins over Writeback, x0 never forwards.
module fwd_sel
  import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       regwrite_m,
    input  logic       regwrite_w,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_NONE;
        if (regwrite_m && (rd_m != '0) && (rd_m == rs))
            fwd = FWD_M;
        else if (regwrite_w && (rd_w != '0) && (rd_w == rs))
            fwd = FWD_W;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait freeze,
// operand forwarding, stall performance counter and sticky memory timeout.
module hazard_ctrl
  import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
)(
    input  logic             clk,
    input  logic             reset,
    hazard_ctrl_if.slave     hz,
    output logic [CNT_W-1:0] StallCount,
    output logic             MemTimeout
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    hz_state_t         state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_nx;
    logic              mem_wait, lw_stall, timeout_hit;
    logic              stall_f, stall_d, stall_e, stall_m;
    logic              flush_d, flush_e, flush_w;
    logic [1:0]        fwd_a, fwd_b;

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (v >= WAIT_MAX) ? v : v + 1'b1;
    endfunction

    assign mem_wait = hz.MemReqM & ~hz.MemReadyM;
    assign lw_stall = hz.ResultSrcE0 & (hz.RdE != '0) &
                      ((hz.Rs1D == hz.RdE) | (hz.Rs2D == hz.RdE));

    always_comb begin
        state_nx    = state;
        wait_nx     = wait_cnt;
        timeout_hit = 1'b0;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_w     = 1'b0;

        // The entry cycle is itself a wait cycle, so the count restarts at one
        // rather than zero; the timeout then lands after the MEM_TIMEOUT-th cycle.
        unique case (state)
            RUN: if (mem_wait) begin
                state_nx    = MEM_WAIT;
                wait_nx     = sat_inc('0);
                timeout_hit = (wait_nx >= WAIT_MAX);
            end
            MEM_WAIT: if (hz.MemReadyM) begin
                state_nx = RUN;
            end else begin
                wait_nx     = sat_inc(wait_cnt);
                timeout_hit = (wait_nx >= WAIT_MAX);
            end
        endcase

        if (reset) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else if (mem_wait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (hz.PCSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            wait_cnt   <= '0;
            StallCount <= '0;
            MemTimeout <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            if (stall_f && (StallCount != '1))
                StallCount <= StallCount + 1'b1;
            if (timeout_hit)
                MemTimeout <= 1'b1;
        end
    end

    fwd_sel u_fwd_a (
        .rs         (hz.Rs1E),
        .rd_m       (hz.RdM),
        .rd_w       (hz.RdW),
        .regwrite_m (hz.RegWriteM),
        .regwrite_w (hz.RegWriteW),
        .fwd        (fwd_a)
    );

    fwd_sel u_fwd_b (
        .rs         (hz.Rs2E),
        .rd_m       (hz.RdM),
        .rd_w       (hz.RdW),
        .regwrite_m (hz.RegWriteM),
        .regwrite_w (hz.RegWriteW),
        .fwd        (fwd_b)
    );

    assign hz.StallF    = stall_f;
    assign hz.StallD    = stall_d;
    assign hz.StallE    = stall_e;
    assign hz.StallM    = stall_m;
    assign hz.FlushD    = flush_d;
    assign hz.FlushE    = flush_e;
    assign hz.FlushW    = flush_w;
    assign hz.ForwardAE = reset ? FWD_NONE : fwd_a;
    assign hz.ForwardBE = reset ? FWD_NONE : fwd_b;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: driver queues expected outputs per cycle,
// a monitor on the falling edge pops and compares them.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] StallCount;
    logic       MemTimeout;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .hz         (hz),
        .StallCount (StallCount),
        .MemTimeout (MemTimeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [3:0] st;   // F,D,E,M
        logic [2:0] fl;   // D,E,W
        logic [1:0] fa;
        logic [1:0] fb;
        logic [3:0] sc;
        logic       to;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   sc_m  = 0;

    task automatic clr();
        hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0; hz.RdE = '0;
        hz.ResultSrcE0 = 1'b0; hz.PCSrcE = 1'b0;
        hz.RdM = '0; hz.RdW = '0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
    endtask

    // Queue this cycle's expectation, advance the stall-count model, move to next cycle.
    task automatic issue(input string nm, input logic [3:0] st, input logic [2:0] fl,
                         input logic [1:0] fa, input logic [1:0] fb, input logic to);
        exp_t e;
        e.nm = nm; e.st = st; e.fl = fl; e.fa = fa; e.fb = fb; e.to = to;
        e.sc = 4'(sc_m);
        q.push_back(e);
        if (reset) sc_m = 0;
        else if (st[3] && sc_m < 15) sc_m = sc_m + 1;
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input string f, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s actual=%h expected=%h @%0t", nm, f, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.nm, "stall", 8'({hz.StallF, hz.StallD, hz.StallE, hz.StallM}), 8'(e.st));
                chk(e.nm, "flush", 8'({hz.FlushD, hz.FlushE, hz.FlushW}), 8'(e.fl));
                chk(e.nm, "fwdA",  8'(hz.ForwardAE), 8'(e.fa));
                chk(e.nm, "fwdB",  8'(hz.ForwardBE), 8'(e.fb));
                chk(e.nm, "count", 8'(StallCount), 8'(e.sc));
                chk(e.nm, "tmo",   8'(MemTimeout), 8'(e.to));
            end
        end
    end

    initial begin : driver
        reset = 1'b1;
        clr();
        hz.RdM = 5'd7; hz.Rs1E = 5'd7; hz.RegWriteM = 1'b1; hz.MemReqM = 1'b1; hz.PCSrcE = 1'b1;
        @(posedge clk); #1;
        issue("rst", 4'b0000, 3'b111, 2'b00, 2'b00, 1'b0);

        reset = 1'b0;
        clr(); issue("idle", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        clr(); hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd5; hz.Rs1D = 5'd5;
        issue("lw_use", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);
        clr(); hz.RdW = 5'd5; hz.RegWriteW = 1'b1; hz.Rs1E = 5'd5;
        issue("lw_fwdW", 4'b0000, 3'b000, 2'b01, 2'b00, 1'b0);
        clr(); hz.PCSrcE = 1'b1; hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd5; hz.Rs2D = 5'd5;
        issue("br_lw", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0);
        clr(); hz.ResultSrcE0 = 1'b1;
        issue("lw_rd0", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        clr(); hz.RdM = 5'd7; hz.RdW = 5'd7; hz.Rs2E = 5'd7; hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1;
        issue("fwd_pri", 4'b0000, 3'b000, 2'b00, 2'b10, 1'b0);
        hz.RdM = 5'd0; hz.Rs1E = 5'd3;
        issue("fwd_rdm0", 4'b0000, 3'b000, 2'b00, 2'b01, 1'b0);
        clr(); hz.RdM = 5'd9; hz.RegWriteM = 1'b1; hz.Rs1E = 5'd9; hz.Rs2E = 5'd9;
        issue("fwd_m", 4'b0000, 3'b000, 2'b10, 2'b10, 1'b0);
        hz.RegWriteM = 1'b0;
        issue("fwd_nowr", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        // Memory wait masks a pending branch and a load-use; forwarding stays live.
        clr(); hz.MemReqM = 1'b1; hz.PCSrcE = 1'b1; hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd5;
        hz.Rs1D = 5'd5; hz.RdM = 5'd4; hz.RegWriteM = 1'b1; hz.Rs1E = 5'd4;
        repeat (3) issue("memwait", 4'b1111, 3'b001, 2'b10, 2'b00, 1'b0);
        hz.MemReadyM = 1'b1;
        issue("mem_rel", 4'b0000, 3'b110, 2'b10, 2'b00, 1'b0);
        clr(); issue("post_wait", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        clr(); hz.MemReqM = 1'b1;
        for (int i = 0; i < 6; i++) issue("tmo_wait", 4'b1111, 3'b001, 2'b00, 2'b00, (i >= 4));
        hz.MemReadyM = 1'b1;
        issue("tmo_sticky", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b1);
        clr(); issue("tmo_hold", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b1);

        hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd6; hz.Rs2D = 5'd6;
        repeat (6) issue("sat", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b1);
        clr(); issue("sat_hold", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b1);

        clr(); hz.MemReqM = 1'b1;
        repeat (2) issue("wait2", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1);
        reset = 1'b1; hz.RdM = 5'd4; hz.RegWriteM = 1'b1; hz.Rs1E = 5'd4;
        issue("rst_mid", 4'b0000, 3'b111, 2'b00, 2'b00, 1'b1);
        reset = 1'b0; clr();
        repeat (5) issue("post_rst", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd6; hz.Rs2D = 5'd6;
        issue("lw_rs2", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);
        clr();

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain actual=%0d expected=0 entries left", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
